// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared owner/tag types for the memory port arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_I};

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_tag_pipe.sv
// ============================================================================
// arb_tag_pipe : MEM_LAT-deep {valid, owner} shift pipe with fetch-tag clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  tag_t push_tag,
  input  logic clear_i,
  output tag_t head
);

  tag_t stage_q [MEM_LAT];
  tag_t stage_d [MEM_LAT];

  // Fetch tags are dropped as they shift so a flush kills every I read in flight.
  always_comb begin
    stage_d[0] = push_tag;
    for (int k = 1; k < MEM_LAT; k++) begin
      stage_d[k] = stage_q[k-1];
      if (clear_i && stage_q[k-1].owner == OWN_I) begin
        stage_d[k].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < MEM_LAT; k++) begin
        stage_q[k] <= TAG_NONE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign head = stage_q[MEM_LAT-1];

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one pipelined memory port between fetch and data
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byteen,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byteen,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                i_win;
  tag_t                push_tag;
  tag_t                head;

  always_comb begin
    // D normally wins; a starved fetch takes one grant unless it is being flushed.
    i_win      = i_req && !i_flush && (!d_req || starve_q == STARVE_LIMIT);
    i_gnt      = reset && i_win;
    d_gnt      = reset && d_req && !i_win;
    mem_en     = i_gnt | d_gnt;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteen = '0;
    push_tag   = TAG_NONE;
    if (d_gnt) begin
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
      mem_byteen = d_byteen;
      if (d_byteen == '0) begin
        push_tag = '{valid: 1'b1, owner: OWN_D};
      end
    end else if (i_gnt) begin
      mem_addr = i_addr;
      push_tag = '{valid: 1'b1, owner: OWN_I};
    end
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIMIT) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  arb_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .push_tag (push_tag),
    .clear_i  (i_flush),
    .head     (head)
  );

  assign i_rvalid = reset && head.valid && head.owner == OWN_I && !i_flush;
  assign d_rvalid = reset && head.valid && head.owner == OWN_D;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

`default_nettype wire
